mac_requant: RTL

Output-side requantizer for the `mac` datapath. It accepts signed 16-bit MAC results over a valid/ready stream and applies a rounding arithmetic right shift, optional ReLU and saturation. It returns signed 8-bit words over a second valid/ready stream. It sits between the MAC/accumulator array and the activation write-back path, narrowing the 8x8→16 products back to operand width.

---
 rtl/mac_requant.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mac_requant.sv
// mac_requant -- output-side requantizer for the mac datapath.
//
// Takes signed IN_WIDTH MAC results over a valid/ready stream, applies a
// round-half-up arithmetic right shift, optional ReLU and saturation to a
// signed OUT_WIDTH word, and returns the result over a second valid/ready
// stream through a two-stage pipeline (2-cycle latency, 1 word/cycle).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   shift      right-shift amount, sampled with each accepted input
//   relu_en    clamp negatives to 0, sampled with each accepted input
//   s_valid    input word valid
//   s_ready    block can accept input (combinational from m_ready)
//   s_data     signed input value
//   m_valid    output word valid
//   m_ready    downstream accepts output
//   m_data     signed requantized value
//   sat_clr    synchronous clear of sat_count (wins over increment)
//   sat_count  saturated words delivered; sticks at 0xFFFF
module mac_requant #(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SHIFT_WIDTH-1:0]      shift,
  input  logic                        relu_en,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [IN_WIDTH-1:0]  s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [OUT_WIDTH-1:0] m_data,
  input  logic                        sat_clr,
  output logic [15:0]                 sat_count
);

  // One extra bit so the rounding add can never overflow.
  localparam int RW = IN_WIDTH + 1;

  localparam logic signed [RW-1:0] MAX_R = RW'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [RW-1:0] MIN_R = RW'(-(2 ** (OUT_WIDTH - 1)));

  localparam logic [OUT_WIDTH-1:0] MAX_OUT = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_OUT = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  // Stage 1: shifted/rounded value plus the ReLU flag it was accepted with.
  logic                 v1;
  logic signed [RW-1:0] r1;
  logic                 relu1;

  // Stage 2: final output word plus its saturation flag.
  logic                 v2;
  logic [OUT_WIDTH-1:0] d2;
  logic                 sat2;

  logic adv2;
  logic move;
  logic in_xfer;
  logic out_xfer;

  assign adv2     = !v2 || m_ready;
  assign s_ready  = !v1 || adv2;
  assign move     = v1 && adv2;
  assign in_xfer  = s_valid && s_ready;
  assign out_xfer = v2 && m_ready;

  assign m_valid = v2;
  assign m_data  = d2;

  // Stage-1 arithmetic: (x + half_lsb) >>> shift, with half_lsb = 0 at shift 0.
  logic signed [RW-1:0] ext;
  logic signed [RW-1:0] bias;
  logic signed [RW-1:0] rnd_sum;
  logic signed [RW-1:0] r_next;

  always_comb begin
    ext     = {s_data[IN_WIDTH-1], s_data};
    bias    = (shift == '0) ? '0 : (RW'(1) << (shift - 1'b1));
    rnd_sum = ext + bias;
    r_next  = rnd_sum >>> shift;
  end

  // Stage-2 clamp: ReLU first (a zeroed word is not a saturation), then
  // saturate to the signed output range, otherwise truncate.
  logic [OUT_WIDTH-1:0] q_data;
  logic                 q_sat;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the if-chain can leave it unassigned and infer a latch.
    q_data = r1[OUT_WIDTH-1:0];
    q_sat  = 1'b0;
    if (relu1 && r1[RW-1]) begin
      q_data = '0;
    end else if (r1 > MAX_R) begin
      q_data = MAX_OUT;
      q_sat  = 1'b1;
    end else if (r1 < MIN_R) begin
      q_data = MIN_OUT;
      q_sat  = 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register in
  // this block samples the pre-edge values, matching real flip-flop behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      r1        <= '0;
      relu1     <= 1'b0;
      v2        <= 1'b0;
      d2        <= '0;
      sat2      <= 1'b0;
      sat_count <= '0;
    end else begin
      if (in_xfer) begin
        v1    <= 1'b1;
        r1    <= r_next;
        relu1 <= relu_en;
      end else if (move) begin
        v1 <= 1'b0;
      end

      // Stage 2 only changes when it is free to advance; otherwise the
      // presented word holds stable under backpressure.
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          d2   <= q_data;
          sat2 <= q_sat;
        end
      end

      if (sat_clr) begin
        sat_count <= '0;
      end else if (out_xfer && sat2 && (sat_count != 16'hFFFF)) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end

endmodule
